// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default
// frame-format parameters.
package uart_rx_pkg;

    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line. Both flops reset to 1, which is
// the idle line level, so reset does not look like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, LSB-first. Defining UART_RX_FRAME_ERR_EN
// adds a frame_err output that flags a low stop bit.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic       rx_done_tick,
    output logic [7:0] dout
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    // The stop phase can run past 16 ticks (1.5 / 2 stop bits).
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    state_e            state_reg, state_d;
    logic [SW-1:0]     s_reg, s_d;
    logic [2:0]        n_reg, n_d;
    logic [DBIT-1:0]   b_reg, b_d;
    logic              rx_s;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_d;
            s_reg     <= s_d;
            n_reg     <= n_d;
            b_reg     <= b_d;
        end
    end

    always_comb begin
        state_d      = state_reg;
        s_d          = s_reg;
        n_d          = n_reg;
        b_d          = b_reg;
        rx_done_tick = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == SW'(7)) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == SW'(15)) begin
                        s_d = '0;
                        // Shift right with the new bit entering at the MSB; works for DBIT=1 too.
                        b_d = DBIT'({rx_s, b_reg} >> 1);
                        if (n_reg == 3'(DBIT - 1)) state_d = STOP;
                        else                        n_d = n_reg + 1'b1;
                    end else begin
                        s_d = s_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == SW'(SB_TICK - 1)) begin
                        rx_done_tick = 1'b1;
                        state_d      = IDLE;
                        s_d          = '0;
                    end else begin
                        s_d = s_reg + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout            = '0;
        dout[DBIT-1:0]  = b_reg;
    end

`ifdef UART_RX_FRAME_ERR_EN
    assign frame_err = rx_done_tick & ~rx_s;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed + random bench for uart_rx; the model is a queue of bytes expected
// to come out, one entry per complete frame sent on the line.
module tb_uart_rx;

    localparam int TDIV = 16;          // clk per s_tick
    localparam int BIT  = 16 * TDIV;   // clk per bit period

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       ferr;
    logic       tick_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       ferr_q[$];

`ifdef UART_RX_FRAME_ERR_EN
    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .dout(dout), .frame_err(ferr)
    );
`else
    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .dout(dout)
    );
    assign ferr = 1'b0;
`endif

    always #10 clk = ~clk;

    // s_tick generator: one clk-wide pulse every TDIV clocks while enabled.
    initial begin
        int cnt;
        cnt    = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                cnt    = (cnt == TDIV - 1) ? 0 : cnt + 1;
                s_tick = (cnt == 0);
            end else begin
                s_tick = 1'b0;
            end
        end
    end

    // Capture every completion pulse away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rx_done_tick) begin
                got_q.push_back(dout);
                ferr_q.push_back(ferr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_start();
        rx = 1'b0;
        wclk(BIT);
    endtask

    task automatic send_rest(input logic [7:0] d, input logic stop_lvl);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wclk(BIT);
        end
        rx = stop_lvl;
        wclk(BIT);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d);
        send_start();
        send_rest(d, 1'b1);
        exp_q.push_back(d);
    endtask

    // Compare everything received so far against the model, then clear both.
    task automatic drain(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
            chk({tag, "_ferr"}, ferr_q.pop_front(), 1'b0);
        end
        exp_q.delete();
        got_q.delete();
        ferr_q.delete();
    endtask

    initial begin
        logic [7:0] d, prev;
        reset   = 1'b1;
        rx      = 1'b1;
        tick_en = 1'b0;
        wclk(5);

        // Reset state
        chk("rst_state", dut.state_reg, 2'b00);
        chk("rst_s", dut.s_reg, 0);
        chk("rst_n", dut.n_reg, 0);
        chk("rst_b", dut.b_reg, 0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", rx_done_tick, 1'b0);
        reset   = 1'b0;
        tick_en = 1'b1;
        wclk(3 * TDIV);

        // Directed byte 0xD1 (bits 1,0,0,0,1,0,1,1 LSB first)
        send_frame(8'hD1);
        wclk(4 * TDIV);
        drain("d1");
        chk("d1_dout", dout, 8'hD1);
        chk("d1_idle", dut.state_reg, 2'b00);

        // Start-bit glitch of 3 tick periods
        rx = 1'b0;
        wclk(3 * TDIV);
        rx = 1'b1;
        wclk(12 * TDIV);
        chk("glitch_state", dut.state_reg, 2'b00);
        chk("glitch_done", got_q.size(), 0);
        chk("glitch_dout", dout, 8'hD1);

        // Reset mid-DATA after 4 bits
        send_start();
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wclk(BIT);
        end
        wclk(BIT / 4);
        chk("mid_n", dut.n_reg, 4);
        chk("mid_state", dut.state_reg, 2'b10);
        reset = 1'b1;
        rx    = 1'b1;
        wclk(3);
        chk("mrst_state", dut.state_reg, 2'b00);
        chk("mrst_b", dut.b_reg, 0);
        chk("mrst_dout", dout, 8'h00);
        reset = 1'b0;
        wclk(2 * BIT);
        chk("mrst_done", got_q.size(), 0);
        send_frame(8'h55);
        wclk(4 * TDIV);
        drain("after_rst");

        // Back-to-back frames, single stop bit each
        send_frame(8'h00);
        send_frame(8'hFF);
        wclk(4 * TDIV);
        drain("b2b");
        chk("b2b_dout", dout, 8'hFF);

        // No s_tick with rx low: parked in START with s_reg at 0
        tick_en = 1'b0;
        wclk(2 * TDIV);
        rx = 1'b0;
        wclk(200);
        chk("stall_state", dut.state_reg, 2'b01);
        chk("stall_s", dut.s_reg, 0);
        wclk(300);
        chk("stall_state2", dut.state_reg, 2'b01);
        chk("stall_s2", dut.s_reg, 0);
        rx      = 1'b1;
        tick_en = 1'b1;
        wclk(12 * TDIV);
        chk("stall_idle", dut.state_reg, 2'b00);
        chk("stall_done", got_q.size(), 0);

`ifdef UART_RX_FRAME_ERR_EN
        // Low stop bit flags a frame error with the byte still delivered
        send_start();
        send_rest(8'hA5, 1'b0);
        wclk(BIT);
        chk("ferr_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("ferr_byte", got_q.pop_front(), 8'hA5);
            chk("ferr_flag", ferr_q.pop_front(), 1'b1);
        end
        got_q.delete();
        ferr_q.delete();
        wclk(2 * BIT);
`endif

        // Random frames; dout must keep the old byte through the start bit
        prev = dout;
        for (int k = 0; k < 8; k++) begin
            d = 8'($urandom);
            send_start();
            chk("hold_dout", dout, prev);
            send_rest(d, 1'b1);
            exp_q.push_back(d);
            prev = d;
            wclk($urandom_range(2 * TDIV, 3 * BIT));
        end
        drain("rand");
        chk("rand_dout", dout, prev);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
